// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and helpers for the register slave.
package axi_lite_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  // Merge new_val into old_val one byte lane at a time, keeping lanes whose strobe is low.
  function automatic data_t apply_wstrb(data_t old_val, data_t new_val, strb_t strb);
    data_t merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers to local logic.
// The write and read channels run as independent always blocks.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 16,
  parameter addr_t BASE_ADDR = 32'h0000_0000
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [31:0]              awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr
);

  localparam int    IDX_W  = $clog2(NUM_REGS);
  localparam addr_t WINDOW = addr_t'(NUM_REGS * 4);

  data_t            regs [NUM_REGS];
  logic             aw_held;
  logic             w_held;
  addr_t            aw_addr_q;
  data_t            w_data_q;
  strb_t            w_strb_q;
  addr_t            aw_off;
  addr_t            ar_off;
  logic             aw_hit;
  logic             ar_hit;
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  r_state_t         r_state;

  assign aw_off = aw_addr_q - BASE_ADDR;
  assign ar_off = araddr - BASE_ADDR;
  assign aw_hit = aw_off < WINDOW;
  assign ar_hit = ar_off < WINDOW;
  assign aw_idx = aw_off[2 +: IDX_W];
  assign ar_idx = ar_off[2 +: IDX_W];

  // A pending B response blocks both write channels so only one write is ever in flight.
  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      reg_wr    <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      reg_wr <= '0;
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (aw_held && w_held) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        if (aw_hit) begin
          regs[aw_idx]   <= apply_wstrb(regs[aw_idx], w_data_q, w_strb_q);
          reg_wr[aw_idx] <= 1'b1;
          bresp          <= RESP_OKAY;
        end else begin
          bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Reads sample regs before any same-edge commit, so a colliding read returns the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            rdata   <= ar_hit ? regs[ar_idx] : '0;
            rresp   <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[32*i +: 32] = regs[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: expectations are queued when a request
// is driven and popped when the matching B or R beat appears.
module tb_axi_lite_reg_slave;
  import axi_lite_pkg::*;

  localparam int NUM_REGS = 16;

  typedef struct {
    resp_t resp;
    logic  hit;
    int    idx;
    data_t val;
  } b_exp_t;

  logic                   aclk;
  logic                   areset;
  logic [31:0]            awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [31:0]            araddr;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0]    reg_wr;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  data_t       model_regs [NUM_REGS];
  b_exp_t      exp_b_q [$];
  logic [33:0] exp_r_q [$];

  axi_lite_reg_slave #(.NUM_REGS(NUM_REGS), .BASE_ADDR(32'h0000_0000)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [511:0] model_flat();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[32*i +: 32] = model_regs[i];
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    check_output({tag, "_outputs"},
                 {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata, reg_wr},
                 {3'b111, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0, 16'h0});
    check_output({tag, "_regs"}, reg_q, '0);
  endtask

  task automatic push_write_exp(input addr_t addr, input data_t data, input strb_t strb);
    b_exp_t e;
    data_t  mask;
    e.hit  = addr < 32'h40;
    e.idx  = int'(addr[5:2]);
    e.resp = e.hit ? 2'b00 : 2'b10;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
    e.val = (model_regs[e.idx] & ~mask) | (data & mask);
    exp_b_q.push_back(e);
  endtask

  task automatic hs_loop();
    int   guard;
    logic aw_hs;
    logic w_hs;
    guard = 0;
    while ((awvalid || wvalid) && guard < 50) begin
      @(negedge aclk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk);
      #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      guard++;
    end
    check_output("aw_w_accepted", {awvalid, wvalid}, 2'b00);
  endtask

  task automatic send_write(input addr_t addr, input data_t data, input strb_t strb, input int w_lead);
    push_write_exp(addr, data, strb);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    if (w_lead > 0) begin
      hs_loop();
      repeat (w_lead - 1) begin
        @(negedge aclk);
        check_output("no_early_bvalid", bvalid, 1'b0);
        check_output("no_early_commit", reg_q, model_flat());
        @(posedge aclk);
        #1;
      end
    end
    awvalid = 1'b1;
    hs_loop();
  endtask

  task automatic collect_b(input int exp_lat, input int hold);
    b_exp_t e;
    int     lat;
    lat = 0;
    @(negedge aclk);
    while (!bvalid && lat < 20) begin
      @(posedge aclk);
      lat++;
      @(negedge aclk);
    end
    check_output("b_latency", lat, exp_lat);
    check_output("b_queue_size", exp_b_q.size(), 1);
    if (exp_b_q.size() == 0) return;
    e = exp_b_q.pop_front();
    if (e.hit) model_regs[e.idx] = e.val;
    check_output("bresp", bresp, e.resp);
    check_output("reg_q_after_write", reg_q, model_flat());
    if (exp_lat == 1) check_output("reg_wr_pulse", reg_wr, e.hit ? (16'h1 << e.idx) : 16'h0);
    for (int i = 0; i < hold; i++) begin
      check_output("b_backpressure", {bvalid, bresp, awready, wready}, {1'b1, e.resp, 2'b00});
      @(posedge aclk);
      @(negedge aclk);
    end
    bready = 1'b1;
    @(posedge aclk);
    #1;
    bready = 1'b0;
    check_output("b_done", {bvalid, reg_wr}, 17'h0);
  endtask

  task automatic send_read(input addr_t addr);
    int guard;
    exp_r_q.push_back((addr < 32'h40) ? {2'b00, model_regs[addr[5:2]]} : {2'b10, 32'h0});
    araddr  = addr;
    arvalid = 1'b1;
    guard   = 0;
    while (arvalid && guard < 50) begin
      @(negedge aclk);
      if (arready) begin
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
      end else begin
        @(posedge aclk);
        #1;
      end
      guard++;
    end
    check_output("ar_accepted", arvalid, 1'b0);
  endtask

  task automatic collect_r(input int exp_lat, input int hold);
    logic [33:0] e;
    int          lat;
    lat = 0;
    @(negedge aclk);
    while (!rvalid && lat < 20) begin
      @(posedge aclk);
      lat++;
      @(negedge aclk);
    end
    check_output("r_latency", lat, exp_lat);
    check_output("r_queue_size", exp_r_q.size(), 1);
    if (exp_r_q.size() == 0) return;
    e = exp_r_q.pop_front();
    check_output("rdata", rdata, e[31:0]);
    check_output("rresp", rresp, e[33:32]);
    for (int i = 0; i < hold; i++) begin
      check_output("r_backpressure", {rvalid, rresp, rdata, arready}, {1'b1, e, 1'b0});
      @(posedge aclk);
      @(negedge aclk);
    end
    rready = 1'b1;
    @(posedge aclk);
    #1;
    rready = 1'b0;
    check_output("r_done", {rvalid, arready}, 2'b01);
  endtask

  task automatic apply_stimulus();
    // Same-cycle AW+W, then read back.
    send_write(32'h08, 32'hDEADBEEF, 4'hF, 0);
    collect_b(1, 0);
    check_output("reg2_value", reg_q[95:64], 32'hDEADBEEF);
    send_read(32'h08);
    collect_r(0, 0);

    // W leads AW by three cycles, partial strobes.
    send_write(32'h04, 32'hAAAAAAAA, 4'hF, 0);
    collect_b(1, 0);
    send_write(32'h04, 32'h11223344, 4'h5, 3);
    collect_b(1, 0);
    check_output("reg1_merge", reg_q[63:32], 32'hAA22AA44);

    // Out-of-range accesses.
    send_write(32'h40, 32'h12345678, 4'hF, 0);
    collect_b(1, 0);
    send_read(32'h40);
    collect_r(0, 0);

    // B backpressure with a second AW offered while blocked.
    send_write(32'h10, 32'h55555555, 4'hF, 0);
    awaddr  = 32'h14;
    awvalid = 1'b1;
    collect_b(1, 5);
    send_write(32'h14, 32'h66666666, 4'h3, 0);
    collect_b(1, 0);

    // Read colliding with a commit to reg 3 sees the old value.
    send_write(32'h0C, 32'h1, 4'hF, 0);
    collect_b(1, 0);
    push_write_exp(32'h0C, 32'h2, 4'hF);
    awaddr  = 32'h0C;
    wdata   = 32'h2;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(posedge aclk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    exp_r_q.push_back({2'b00, model_regs[3]});
    araddr  = 32'h0C;
    arvalid = 1'b1;
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
    check_output("collide_reg_wr", reg_wr, 16'h0008);
    collect_r(0, 4);
    collect_b(0, 0);
    send_read(32'h0C);
    collect_r(0, 0);

    // Reset with B and R both pending and an AR held.
    send_write(32'h0C, 32'h77, 4'hF, 0);
    send_read(32'h08);
    @(negedge aclk);
    check_output("pre_reset_pending", {bvalid, rvalid}, 2'b11);
    araddr  = 32'h04;
    arvalid = 1'b1;
    areset  = 1'b1;
    @(posedge aclk);
    #1;
    areset  = 1'b0;
    arvalid = 1'b0;
    check_reset_state("mid_reset");
    exp_b_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;

    send_write(32'h20, 32'hCAFEF00D, 4'hF, 0);
    collect_b(1, 0);
    send_read(32'h20);
    collect_r(0, 0);
    send_read(32'h0C);
    collect_r(0, 0);
  endtask

  initial begin
    areset  = 1'b1;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    check_reset_state("reset");
    apply_stimulus();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
